round_recorder: RTL and testbench

ROUND_RECORDER -- requirements
Module: round_recorder

---
 rtl/round_recorder.sv | 113 +++++++++++
 tb/tb_round_recorder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/round_recorder.sv
// rtl/round_recorder.sv - rock/paper/scissors match recorder with per-round result history
module round_recorder #(
    parameter int ROUNDS = 5
) (
    input  logic                  newClk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  play,
    input  logic [1:0]            p1_move,
    input  logic [1:0]            p2_move,
    output logic [2*ROUNDS-1:0]   out_cr,
    output logic [2:0]            round_cnt,
    output logic                  done,
    output logic                  err
);

    // Move encoding: 01 rock, 10 paper, 11 scissors, 00 none.
    localparam logic [1:0] MV_ROCK     = 2'b01;
    localparam logic [1:0] MV_PAPER    = 2'b10;
    localparam logic [1:0] MV_SCISSORS = 2'b11;

    // Slot encoding.
    localparam logic [1:0] RES_P1  = 2'b01;
    localparam logic [1:0] RES_P2  = 2'b10;
    localparam logic [1:0] RES_TIE = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        FULL    = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [2*ROUNDS-1:0]   hist_q, hist_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  moves_valid;
    logic                  p1_wins;
    logic [1:0]            result;

    // Decide the outcome of the presented move pair.
    always_comb begin
        moves_valid = (p1_move != 2'b00) && (p2_move != 2'b00);
        p1_wins     = ((p1_move == MV_ROCK)     && (p2_move == MV_SCISSORS)) ||
                      ((p1_move == MV_SCISSORS) && (p2_move == MV_PAPER))    ||
                      ((p1_move == MV_PAPER)    && (p2_move == MV_ROCK));
        if (p1_move == p2_move) begin
            result = RES_TIE;
        end else if (p1_wins) begin
            result = RES_P1;
        end else begin
            result = RES_P2;
        end
    end

    // Next-state logic: clear dominates play; rejected plays only raise err.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = 1'b0;

        if (clear) begin
            state_d = IDLE;
            hist_d  = '0;
            cnt_d   = 3'd0;
            done_d  = 1'b0;
        end else if (play) begin
            if (!moves_valid || (state_q == FULL)) begin
                err_d = 1'b1;
            end else begin
                for (int k = 0; k < ROUNDS; k++) begin
                    if (cnt_q == 3'(k)) begin
                        hist_d[2*k +: 2] = result;
                    end
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(ROUNDS - 1)) begin
                    state_d = FULL;
                    done_d  = 1'b1;
                end else begin
                    state_d = COLLECT;
                end
            end
        end
    end

    // State register; reset acts immediately without waiting for a clock edge.
    always_ff @(posedge newClk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hist_q  <= '0;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out_cr    = hist_q;
    assign round_cnt = cnt_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_round_recorder.sv
// tb/tb_round_recorder.sv - directed self-checking bench for round_recorder
module tb_round_recorder;

    logic        newClk;
    logic        rst;
    logic        clear;
    logic        play;
    logic [1:0]  p1_move;
    logic [1:0]  p2_move;
    logic [9:0]  out_cr;
    logic [2:0]  round_cnt;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    round_recorder #(.ROUNDS(5)) dut (
        .newClk    (newClk),
        .rst       (rst),
        .clear     (clear),
        .play      (play),
        .p1_move   (p1_move),
        .p2_move   (p2_move),
        .out_cr    (out_cr),
        .round_cnt (round_cnt),
        .done      (done),
        .err       (err)
    );

    initial newClk = 1'b0;
    always #5 newClk = ~newClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [9:0] e_out, input logic [2:0] e_cnt,
                             input logic e_done, input logic e_err);
        check({tag, ".out_cr"},    32'(out_cr),    32'(e_out));
        check({tag, ".round_cnt"}, 32'(round_cnt), 32'(e_cnt));
        check({tag, ".done"},      32'(done),      32'(e_done));
        check({tag, ".err"},       32'(err),       32'(e_err));
    endtask

    // Present one play strobe for one cycle; return 1 ns after the capturing edge.
    task automatic do_play(input logic [1:0] a, input logic [1:0] b);
        @(negedge newClk);
        play    = 1'b1;
        p1_move = a;
        p2_move = b;
        @(posedge newClk);
        #1;
        play    = 1'b0;
        p1_move = 2'b00;
        p2_move = 2'b00;
    endtask

    task automatic do_clear();
        @(negedge newClk);
        clear = 1'b1;
        @(posedge newClk);
        #1;
        clear = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge newClk);
        #1;
    endtask

    // Expected slot-0 result indexed by (p1-1)*3 + (p2-1); rows rock, paper, scissors.
    logic [1:0] tbl [9];

    initial begin
        tbl[0] = 2'b11; tbl[1] = 2'b10; tbl[2] = 2'b01;
        tbl[3] = 2'b01; tbl[4] = 2'b11; tbl[5] = 2'b10;
        tbl[6] = 2'b10; tbl[7] = 2'b01; tbl[8] = 2'b11;

        rst = 1'b1; clear = 1'b0; play = 1'b0; p1_move = 2'b00; p2_move = 2'b00;
        #2;
        check_all("reset", 10'b0, 3'd0, 1'b0, 1'b0);
        @(negedge newClk);
        @(negedge newClk);
        rst = 1'b0;

        // First play right after reset release lands on the first edge.
        do_play(2'b01, 2'b11);
        check_all("play1", 10'b00_0000_0001, 3'd1, 1'b0, 1'b0);
        do_play(2'b10, 2'b01);
        check_all("play2", 10'b00_0000_0101, 3'd2, 1'b0, 1'b0);

        // Rejected plays at round_cnt=2.
        do_play(2'b01, 2'b00);
        check_all("rej_p2none", 10'b00_0000_0101, 3'd2, 1'b0, 1'b1);
        idle_cycle();
        check_all("rej_p2none_after", 10'b00_0000_0101, 3'd2, 1'b0, 1'b0);
        do_play(2'b00, 2'b10);
        check_all("rej_p1none", 10'b00_0000_0101, 3'd2, 1'b0, 1'b1);

        do_play(2'b11, 2'b11);
        check_all("play3", 10'b00_0011_0101, 3'd3, 1'b0, 1'b0);
        do_play(2'b01, 2'b10);
        check_all("play4", 10'b00_1011_0101, 3'd4, 1'b0, 1'b0);
        do_play(2'b10, 2'b11);
        // slot4..0 = p2 win, p2 win, tie, p1 win, p1 win
        check_all("play5", 10'b10_1011_0101, 3'd5, 1'b1, 1'b0);

        // Sixth play while full.
        do_play(2'b01, 2'b11);
        check_all("play6_full", 10'b10_1011_0101, 3'd5, 1'b1, 1'b1);
        idle_cycle();
        check_all("full_hold", 10'b10_1011_0101, 3'd5, 1'b1, 1'b0);

        // Clear and play together at round_cnt=3.
        do_clear();
        check_all("clear", 10'b0, 3'd0, 1'b0, 1'b0);
        do_play(2'b01, 2'b11);
        do_play(2'b10, 2'b01);
        do_play(2'b11, 2'b11);
        check_all("pre_clrplay", 10'b00_0011_0101, 3'd3, 1'b0, 1'b0);
        @(negedge newClk);
        clear = 1'b1; play = 1'b1; p1_move = 2'b01; p2_move = 2'b10;
        @(posedge newClk);
        #1;
        clear = 1'b0; play = 1'b0; p1_move = 2'b00; p2_move = 2'b00;
        check_all("clear_play", 10'b0, 3'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-match at round_cnt=4.
        do_play(2'b01, 2'b11);
        do_play(2'b10, 2'b01);
        do_play(2'b11, 2'b11);
        do_play(2'b01, 2'b10);
        check_all("pre_rst", 10'b00_1011_0101, 3'd4, 1'b0, 1'b0);
        @(negedge newClk);
        #1;
        rst = 1'b1;
        #1;
        check_all("async_rst", 10'b0, 3'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        do_play(2'b10, 2'b11);
        check_all("post_rst_play", 10'b00_0000_0010, 3'd1, 1'b0, 1'b0);

        // Every valid move pair from IDLE; output must not change before the edge.
        for (int a = 1; a <= 3; a++) begin
            for (int b = 1; b <= 3; b++) begin
                do_clear();
                @(negedge newClk);
                play = 1'b1; p1_move = 2'(a); p2_move = 2'(b);
                #1;
                check($sformatf("pair%0d%0d.before_edge", a, b), 32'(out_cr), 32'd0);
                @(posedge newClk);
                #1;
                play = 1'b0; p1_move = 2'b00; p2_move = 2'b00;
                check($sformatf("pair%0d%0d.slot0", a, b), 32'(out_cr), 32'(tbl[(a-1)*3 + (b-1)]));
                check($sformatf("pair%0d%0d.cnt", a, b), 32'(round_cnt), 32'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
